// File: rtl/mac_frame_sequencer.sv
// Frame sequencer feeding an unsigned multiply-accumulate stage: groups operand
// pairs into frames, inserts the flush edge and holds each frame result.
module mac_frame_sequencer #(
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic [DW-1:0]    mac_dataa,
  output logic [DW-1:0]    mac_datab,
  output logic             mac_clken,
  output logic             mac_sload,
  input  logic [AW-1:0]    mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH_PEND
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len;
  logic             cap_pend;

  logic             flush_ok;
  logic             issue;
  logic             flush_edge;
  logic [LEN_W-1:0] new_len;
  logic [LEN_W-1:0] cnt_inc;

  // A flush may only fire when the result register will be free by the capture edge.
  assign flush_ok   = !cap_pend && (!res_valid || res_ready);
  assign in_ready   = (state == FLUSH_PEND) ? flush_ok : 1'b1;
  assign issue      = in_valid && in_ready;
  assign flush_edge = (state == FLUSH_PEND) && flush_ok;
  assign new_len    = (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign cnt_inc    = cnt + LEN_W'(1);
  assign busy       = (state != IDLE) || cap_pend || res_valid;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    mac_clken = 1'b0;
    mac_sload = 1'b0;
    mac_dataa = in_a;
    mac_datab = in_b;
    if (issue) begin
      mac_clken = 1'b1;
      mac_sload = (state != RUN);
    end else if (flush_edge) begin
      mac_clken = 1'b1;
      mac_sload = 1'b1;
      mac_dataa = '0;
      mac_datab = '0;
    end
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state     <= IDLE;
      cnt       <= '0;
      len       <= '0;
      cap_pend  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE, FLUSH_PEND: begin
          if (issue) begin
            len   <= new_len;
            cnt   <= LEN_W'(1);
            state <= (new_len == LEN_W'(1)) ? FLUSH_PEND : RUN;
          end else if (flush_edge) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (issue) begin
            cnt <= cnt_inc;
            if (cnt_inc == len) state <= FLUSH_PEND;
          end
        end
        default: state <= IDLE;
      endcase

      // The MAC output settles one edge after the flush; flush_edge implies !cap_pend.
      cap_pend <= flush_edge;

      if (cap_pend) begin
        res_data  <= mac_result;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Bench for mac_frame_sequencer: drives a behavioural MAC and checks frame sums
// against a frame-level scoreboard, plus directed timing scenarios.
module tb_mac_frame_sequencer;

  logic        clk = 1'b0;
  logic        aclr;
  logic [7:0]  frame_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  mac_dataa;
  logic [7:0]  mac_datab;
  logic        mac_clken;
  logic        mac_sload;
  logic [15:0] mac_result;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        busy;

  mac_frame_sequencer #(.DW(8), .AW(16), .LEN_W(8)) dut (
    .clk(clk), .aclr(aclr), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_dataa(mac_dataa), .mac_datab(mac_datab), .mac_clken(mac_clken),
    .mac_sload(mac_sload), .mac_result(mac_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: operand register, then accumulate (or load) on the next clken edge.
  logic [7:0]  ra, rb;
  logic        rs;
  logic [15:0] acc;
  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ra <= '0; rb <= '0; rs <= 1'b0; acc <= '0;
    end else if (mac_clken) begin
      ra  <= mac_dataa;
      rb  <= mac_datab;
      rs  <= mac_sload;
      acc <= (rs ? 16'd0 : acc) + ra * rb;
    end
  end
  assign mac_result = acc;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: sum of products over each group of max(len,1) accepted terms.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit          m_open;
  int          m_len, m_cnt;
  logic [15:0] m_sum;

  logic s_in_ready, s_clken, s_sload, s_res_valid;
  logic [7:0]  s_dataa, s_datab;
  logic [15:0] s_res_data;

  task automatic model_term(input logic [7:0] a, input logic [7:0] b, input logic [7:0] fl);
    if (!m_open) begin
      m_len  = (fl == 0) ? 1 : int'(fl);
      m_cnt  = 0;
      m_sum  = '0;
      m_open = 1'b1;
    end
    m_sum = m_sum + a * b;
    m_cnt++;
    if (m_cnt == m_len) begin
      exp_q.push_back(m_sum);
      m_open = 1'b0;
    end
  endtask

  // One clock cycle: entered at a negedge, drives, samples 1 ns later, returns at the next negedge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] fl, input logic rr);
    in_valid = v; in_a = a; in_b = b; frame_len = fl; res_ready = rr;
    #1;
    s_in_ready  = in_ready;
    s_clken     = mac_clken;
    s_sload     = mac_sload;
    s_dataa     = mac_dataa;
    s_datab     = mac_datab;
    s_res_valid = res_valid;
    s_res_data  = res_data;
    if (v && in_ready) model_term(a, b, fl);
    if (res_valid && rr) got_q.push_back(res_data);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 60) begin
      step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout busy=%0b required=0", busy);
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, res_valid, res_data, mac_clken, in_ready} !== {1'b0, 1'b0, 16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_held busy=%0b res_valid=%0b res_data=%0d clken=%0b in_ready=%0b required 0,0,0,0,1",
               busy, res_valid, res_data, mac_clken, in_ready);
    end
    @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, res_valid, mac_clken} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release busy=%0b res_valid=%0b clken=%0b required 0,0,0", busy, res_valid, mac_clken);
    end
  endtask

  task automatic test_len4();
    logic [7:0] av[4] = '{8'd1, 8'd3, 8'd5, 8'd7};
    logic [7:0] bv[4] = '{8'd2, 8'd4, 8'd6, 8'd8};
    clear_queues();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, av[i], bv[i], 8'd4, 1'b1);
      checks++;
      if (s_clken !== 1'b1 || s_sload !== (i == 0)) begin
        errors++;
        $display("FAIL len4_sload term=%0d clken=%0b sload=%0b required 1,%0b", i, s_clken, s_sload, (i == 0));
      end
    end
    step(1'b0, 8'd9, 8'd9, 8'd4, 1'b1);
    checks++;
    if ({s_clken, s_sload, s_dataa, s_datab} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL len4_pure_flush clken=%0b sload=%0b a=%0d b=%0d required 1,1,0,0",
               s_clken, s_sload, s_dataa, s_datab);
    end
    step(1'b0, 8'd0, 8'd0, 8'd4, 1'b1);
    checks++;
    if (s_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL len4_early_valid res_valid=%0b required 0", s_res_valid);
    end
    step(1'b0, 8'd0, 8'd0, 8'd4, 1'b1);
    checks++;
    if (s_res_valid !== 1'b1 || s_res_data !== 16'd100) begin
      errors++;
      $display("FAIL len4_result res_valid=%0b res_data=%0d required 1,100", s_res_valid, s_res_data);
    end
    step(1'b0, 8'd0, 8'd0, 8'd4, 1'b1);
    checks++;
    if (s_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL len4_one_cycle res_valid=%0b required 0", s_res_valid);
    end
  endtask

  task automatic run_len2_frames(input logic rr);
    logic [7:0] v[4] = '{8'd10, 8'd20, 8'd1, 8'd2};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, v[i], v[i], 8'd2, rr);
      checks++;
      if (s_in_ready !== 1'b1 || s_sload !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL len2_issue term=%0d in_ready=%0b sload=%0b required 1,%0b",
                 i, s_in_ready, s_sload, (i % 2 == 0));
      end
    end
  endtask

  task automatic check_500_5(input string name);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 16'd500 || got_q[1] !== 16'd5) begin
      errors++;
      $display("FAIL %s count=%0d first=%0d second=%0d required 2,500,5", name, got_q.size(),
               got_q.size() > 0 ? got_q[0] : 16'hxxxx, got_q.size() > 1 ? got_q[1] : 16'hxxxx);
    end
  endtask

  task automatic test_len2_merged();
    clear_queues();
    run_len2_frames(1'b1);
    drain();
    check_500_5("len2_merged_results");
  endtask

  task automatic test_backpressure();
    clear_queues();
    run_len2_frames(1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'd0, 8'd0, 8'd2, 1'b0);
      checks++;
      if ({s_in_ready, s_clken, s_res_valid, s_res_data} !== {1'b0, 1'b0, 1'b1, 16'd500}) begin
        errors++;
        $display("FAIL bp_hold in_ready=%0b clken=%0b res_valid=%0b res_data=%0d required 0,0,1,500",
                 s_in_ready, s_clken, s_res_valid, s_res_data);
      end
    end
    step(1'b0, 8'd0, 8'd0, 8'd2, 1'b1);
    checks++;
    if ({s_clken, s_sload} !== 2'b11) begin
      errors++;
      $display("FAIL bp_release_flush clken=%0b sload=%0b required 1,1", s_clken, s_sload);
    end
    drain();
    check_500_5("bp_results");
  endtask

  task automatic test_len1();
    logic [7:0] fls[2] = '{8'd1, 8'd0};
    logic       pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      int acc_n = 0;
      clear_queues();
      for (int i = 0; i < 5; i++) begin
        step(acc_n < 3, 8'd255, 8'd255, fls[k], 1'b1);
        if (acc_n < 3 && s_in_ready) acc_n++;
        checks++;
        if (s_in_ready !== pat[i]) begin
          errors++;
          $display("FAIL len1_ready fl=%0d cycle=%0d in_ready=%0b required %0b", fls[k], i, s_in_ready, pat[i]);
        end
      end
      drain();
      checks++;
      if (got_q.size() != 3 || got_q[0] !== 16'd65025 || got_q[1] !== 16'd65025 || got_q[2] !== 16'd65025) begin
        errors++;
        $display("FAIL len1_results fl=%0d count=%0d first=%0d required 3 of 65025", fls[k], got_q.size(),
                 got_q.size() > 0 ? got_q[0] : 16'hxxxx);
      end
    end
  endtask

  task automatic test_wrap();
    clear_queues();
    step(1'b1, 8'd255, 8'd255, 8'd2, 1'b1);
    step(1'b1, 8'd255, 8'd255, 8'd2, 1'b1);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'd64514) begin
      errors++;
      $display("FAIL wrap_result count=%0d value=%0d required 1,64514", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_aclr_mid_frame();
    step(1'b1, 8'd9, 8'd9, 8'd4, 1'b1);
    step(1'b1, 8'd7, 8'd7, 8'd4, 1'b1);
    in_valid = 1'b0;
    #2 aclr = 1'b1;
    #1;
    checks++;
    if ({busy, res_valid, res_data, mac_clken, mac_result} !== {1'b0, 1'b0, 16'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL aclr_async busy=%0b res_valid=%0b res_data=%0d clken=%0b mac=%0d required all 0",
               busy, res_valid, res_data, mac_clken, mac_result);
    end
    m_open = 1'b0;
    @(negedge clk);
    aclr = 1'b0;
    clear_queues();
    step(1'b1, 8'd3, 8'd3, 8'd2, 1'b1);
    step(1'b1, 8'd4, 8'd4, 8'd2, 1'b1);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'd25) begin
      errors++;
      $display("FAIL aclr_no_residue count=%0d value=%0d required 1,25", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    int n = 0;
    clear_queues();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(9, 0) < 7, 8'($urandom), 8'($urandom), 8'($urandom_range(5, 0)),
           $urandom_range(9, 0) < 6);
      if (s_res_valid && !res_ready) begin
        // A held result must stay put until it is taken.
        checks++;
        if (res_valid !== 1'b1 || res_data !== s_res_data) begin
          errors++;
          $display("FAIL rand_hold res_valid=%0b res_data=%0d required 1,%0d", res_valid, res_data, s_res_data);
        end
      end
    end
    while (m_open && n < 300) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'd1, 1'b1);
      n++;
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || exp_q.size() < 50) begin
      errors++;
      $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_result idx=%0d got=%0d required=%0d", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    aclr = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; frame_len = '0; res_ready = 1'b0;
    m_open = 1'b0; m_len = 0; m_cnt = 0; m_sum = '0;
    @(negedge clk);
    test_reset();
    test_len4();
    test_len2_merged();
    test_backpressure();
    test_len1();
    test_wrap();
    test_aclr_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
